// File: rtl/loadunit_if.sv
// -----------------------------------------------------------------------------
// loadunit_if
// Bundles the dispatch buses, memory read data and result broadcast of the
// load reservation station.
//   instbus1 : dispatch bus 1, {tag, opcode, operand, dest}, higher priority
//   instbus2 : dispatch bus 2, same format, lower priority
//   data_in  : memory read data for the load completing on this edge
//   loadout  : registered result broadcast, {tag, data}
// master drives the buses (dispatcher / bench); slave is the load unit.
// -----------------------------------------------------------------------------
interface loadunit_if;
   logic [39:0] instbus1;
   logic [39:0] instbus2;
   logic [31:0] data_in;
   logic [39:0] loadout;

   modport master (
      output instbus1,
      output instbus2,
      output data_in,
      input  loadout
   );

   modport slave (
      input  instbus1,
      input  instbus2,
      input  data_in,
      output loadout
   );
endinterface

// File: rtl/loadunit.sv
// -----------------------------------------------------------------------------
// loadunit
// Two-entry load reservation station plus execution stage. Both dispatch
// buses are snooped for LOAD instructions tagged LD0/LD1; captured loads are
// held in arrival order and the oldest one completes on every edge, putting
// {station tag, memory data} on the result bus.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : loadunit_if.slave (instbus1, instbus2, data_in in; loadout out)
// -----------------------------------------------------------------------------
module loadunit (
   input logic       clk,
   input logic       rst_n,
   loadunit_if.slave bus
);

   localparam logic [7:0] OP_LOAD = 8'h01;
   localparam logic [7:0] TAG_LD0 = 8'h40;
   localparam logic [7:0] TAG_LD1 = 8'h41;

   // A bus word belongs to this unit only when it is a LOAD aimed at LD0/LD1.
   function automatic logic is_load_cand(input logic [39:0] word);
      return (word[31:24] == OP_LOAD) &&
             ((word[39:32] == TAG_LD0) || (word[39:32] == TAG_LD1));
   endfunction

   // Entry index for a station tag: LD0 -> 0, LD1 -> 1.
   function automatic logic tag_to_idx(input logic [39:0] word);
      return word[32];
   endfunction

   // Result word for a completing entry.
   function automatic logic [39:0] make_result(input logic       idx,
                                               input logic [31:0] data);
      return {TAG_LD0[7:1], idx, data};
   endfunction

   // Station state
   logic [1:0]        vld_p0;
   logic              oldest_p0;
   logic [1:0][23:0]  ent_p0;
   logic [39:0]       loadout_p0;

   // Next-state terms
   logic              cand1;
   logic              cand2;
   logic              tgt1;
   logic              tgt2;
   logic              comp_any;
   logic              comp_idx;
   logic [1:0]        free_slot;
   logic [1:0]        held;
   logic              cap1;
   logic              cap2;
   logic [1:0]        vld_nxt;
   logic              oldest_nxt;
   logic [39:0]       loadout_nxt;

   always_comb begin
      cand1       = is_load_cand(bus.instbus1);
      cand2       = is_load_cand(bus.instbus2);
      tgt1        = tag_to_idx(bus.instbus1);
      tgt2        = tag_to_idx(bus.instbus2);

      // The age pointer only arbitrates when both entries are live; with a
      // single live entry that entry is the oldest by definition.
      comp_any    = |vld_p0;
      if (&vld_p0) begin
         comp_idx = oldest_p0;
      end else begin
         comp_idx = vld_p0[1];
      end

      // An entry can accept a new load if it is empty or drains this edge.
      free_slot   = ~vld_p0;
      held        = vld_p0;
      if (comp_any) begin
         free_slot[comp_idx] = 1'b1;
         held[comp_idx]      = 1'b0;
      end

      // Bus 2 loses any same-tag contest with bus 1, even when bus 1 itself
      // is dropped because the entry is busy.
      cap1        = cand1 && free_slot[tgt1];
      cap2        = cand2 && free_slot[tgt2] && !(cand1 && (tgt1 == tgt2));

      vld_nxt     = held;
      if (cap1) begin
         vld_nxt[tgt1] = 1'b1;
      end
      if (cap2) begin
         vld_nxt[tgt2] = 1'b1;
      end

      // A surviving entry is always older than anything captured now; with
      // no survivor, bus 1 wins the age race against bus 2.
      oldest_nxt  = oldest_p0;
      if (|held) begin
         oldest_nxt = held[1];
      end else if (cap1) begin
         oldest_nxt = tgt1;
      end else if (cap2) begin
         oldest_nxt = tgt2;
      end

      if (comp_any) begin
         loadout_nxt = make_result(comp_idx, bus.data_in);
      end else begin
         loadout_nxt = 40'h0;
      end
   end

   // ---- stage p0: station control and result register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p0     <= 2'b00;
         oldest_p0  <= 1'b0;
         loadout_p0 <= 40'h0;
      end else begin
         vld_p0     <= vld_nxt;
         oldest_p0  <= oldest_nxt;
         loadout_p0 <= loadout_nxt;
      end
   end

   // ---- stage p0: station payload (no reset, qualified by vld_p0) ----
   always_ff @(posedge clk) begin
      if (cap1) begin
         ent_p0[tgt1] <= bus.instbus1[23:0];
      end
      if (cap2) begin
         ent_p0[tgt2] <= bus.instbus2[23:0];
      end
   end

   assign bus.loadout = loadout_p0;

endmodule

// File: tb/tb_loadunit.sv
module tb_loadunit;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   loadunit_if lu_if ();

   loadunit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (lu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the station is an age-ordered queue of tags (0 = LD0,
   // 1 = LD1). Each edge pops the head as the completion, then appends
   // every incoming LOAD whose tag is not already queued.
   bit q[$];

   function automatic bit is_cand(input logic [39:0] w);
      return (w[31:24] == 8'h01) && (w[39:32] == 8'h40 || w[39:32] == 8'h41);
   endfunction

   function automatic bit in_q(input bit t);
      foreach (q[i]) if (q[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge(output logic [39:0] e);
      logic [39:0] b1;
      logic [39:0] b2;
      b1 = lu_if.instbus1;
      b2 = lu_if.instbus2;
      if (!rst_n) begin
         q.delete();
         e = 40'h0;
         return;
      end
      if (q.size() > 0) begin
         e = (q[0] ? 40'h41_0000_0000 : 40'h40_0000_0000) | {8'h00, lu_if.data_in};
         void'(q.pop_front());
      end else begin
         e = 40'h0;
      end
      if (is_cand(b1) && !in_q(b1[32])) q.push_back(b1[32]);
      if (is_cand(b2) && !in_q(b2[32])) q.push_back(b2[32]);
   endtask

   // Advance one edge, predicting the result; sample 1 time unit later.
   task automatic step(output logic [39:0] e);
      model_edge(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      lu_if.instbus1 = 40'h0;
      lu_if.instbus2 = 40'h0;
   endtask

   task automatic do_reset();
      logic [39:0] e;
      idle_bus();
      rst_n = 1'b0;
      step(e);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [39:0] e;
      rst_n = 1'b0;
      lu_if.instbus1 = 40'h40_01_1234_10;
      lu_if.instbus2 = 40'h41_01_5678_12;
      lu_if.data_in  = 32'hcafef00d;
      for (int i = 0; i < 2; i++) begin
         step(e);
         checks++;
         if (lu_if.loadout !== 40'h0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: loadout=%h expected %h", i, lu_if.loadout, 40'h0);
         end
      end
      rst_n = 1'b1;
      idle_bus();
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h0) begin
         errors++;
         $display("FAIL reset_nothing_captured: loadout=%h expected %h", lu_if.loadout, 40'h0);
      end
      lu_if.instbus1 = 40'h40_01_0000_01;
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h0) begin
         errors++;
         $display("FAIL reset_capture_edge: loadout=%h expected %h", lu_if.loadout, 40'h0);
      end
      idle_bus();
      lu_if.data_in = 32'h11223344;
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h40_11223344) begin
         errors++;
         $display("FAIL reset_first_completion: loadout=%h expected %h", lu_if.loadout, 40'h40_11223344);
      end
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h0) begin
         errors++;
         $display("FAIL reset_idle_after: loadout=%h expected %h", lu_if.loadout, 40'h0);
      end
   endtask

   task automatic test_dual_held();
      logic [39:0] e;
      logic [39:0] want [4];
      want[0] = 40'h4047bdce12;
      want[1] = 40'h4147bdce12;
      want[2] = 40'h40345612bc;
      want[3] = 40'h41345612bc;
      do_reset();
      lu_if.instbus1 = 40'h40_01_0000_10;
      lu_if.instbus2 = 40'h41_01_0000_12;
      lu_if.data_in  = 32'h47bdce12;
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h0) begin
         errors++;
         $display("FAIL dual_capture_edge: loadout=%h expected %h", lu_if.loadout, 40'h0);
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 2) lu_if.data_in = 32'h345612bc;
         step(e);
         checks++;
         if (lu_if.loadout !== want[i]) begin
            errors++;
            $display("FAIL dual_held[%0d]: loadout=%h expected %h", i, lu_if.loadout, want[i]);
         end
      end
      idle_bus();
      for (int i = 0; i < 3; i++) begin
         lu_if.data_in = 32'h0a0b0c00 + 32'(i);
         step(e);
         checks++;
         if (lu_if.loadout !== e) begin
            errors++;
            $display("FAIL dual_drain[%0d]: loadout=%h expected %h", i, lu_if.loadout, e);
         end
      end
   endtask

   task automatic test_single();
      logic [39:0] e;
      do_reset();
      lu_if.instbus2 = 40'h41_01_0000_20;
      lu_if.data_in  = 32'hdeadbeef;
      step(e);
      idle_bus();
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h41deadbeef) begin
         errors++;
         $display("FAIL single_completion: loadout=%h expected %h", lu_if.loadout, 40'h41deadbeef);
      end
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h0) begin
         errors++;
         $display("FAIL single_then_idle: loadout=%h expected %h", lu_if.loadout, 40'h0);
      end
   endtask

   task automatic test_filter();
      logic [39:0] e;
      do_reset();
      lu_if.instbus1 = 40'h40_02_1111_10;
      lu_if.instbus2 = 40'h50_01_2222_12;
      lu_if.data_in  = 32'h55aa55aa;
      for (int i = 0; i < 3; i++) begin
         step(e);
         checks++;
         if (lu_if.loadout !== 40'h0) begin
            errors++;
            $display("FAIL filter[%0d]: loadout=%h expected %h", i, lu_if.loadout, 40'h0);
         end
      end
      idle_bus();
   endtask

   task automatic test_conflict();
      logic [39:0] e;
      do_reset();
      lu_if.instbus1 = 40'h40_01_0000_10;
      lu_if.instbus2 = 40'h40_01_0000_13;
      step(e);
      idle_bus();
      checks++;
      if (dut.ent_p0[0][7:0] !== 8'h10) begin
         errors++;
         $display("FAIL conflict_dest: entry dest=%h expected %h", dut.ent_p0[0][7:0], 8'h10);
      end
      lu_if.data_in = 32'h13579bdf;
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h4013579bdf) begin
         errors++;
         $display("FAIL conflict_completion: loadout=%h expected %h", lu_if.loadout, 40'h4013579bdf);
      end
      step(e);
      checks++;
      if (lu_if.loadout !== 40'h0) begin
         errors++;
         $display("FAIL conflict_single: loadout=%h expected %h", lu_if.loadout, 40'h0);
      end
   endtask

   task automatic test_busy_drop();
      logic [39:0] e;
      logic [39:0] want [4];
      want[0] = 40'h40_0000_00a0;
      want[1] = 40'h41_0000_00a1;
      want[2] = 40'h40_0000_00a2;
      want[3] = 40'h0;
      do_reset();
      lu_if.instbus1 = 40'h40_01_0000_01;
      step(e);
      lu_if.instbus1 = 40'h41_01_0000_02;
      lu_if.instbus2 = 40'h40_01_0000_03;
      for (int i = 0; i < 4; i++) begin
         lu_if.data_in = 32'h000000a0 + 32'(i);
         step(e);
         idle_bus();
         checks++;
         if (lu_if.loadout !== want[i]) begin
            errors++;
            $display("FAIL busy_drop_order[%0d]: loadout=%h expected %h", i, lu_if.loadout, want[i]);
         end
      end
   endtask

   function automatic logic [39:0] rand_word();
      logic [39:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0, 1: w[39:24] = 16'h4001;
         2, 3: w[39:24] = 16'h4101;
         4:    w[39:24] = {8'h40 | 8'($urandom_range(0, 1)), 8'($urandom_range(2, 255))};
         default: ;
      endcase
      return w;
   endfunction

   task automatic test_random();
      logic [39:0] e;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst_n          = ($urandom_range(0, 60) != 0);
         lu_if.instbus1 = ($urandom_range(0, 3) == 0) ? 40'h0 : rand_word();
         lu_if.instbus2 = ($urandom_range(0, 3) == 0) ? 40'h0 : rand_word();
         lu_if.data_in  = $urandom;
         step(e);
         checks++;
         if (lu_if.loadout !== e) begin
            errors++;
            $display("FAIL random[%0d]: loadout=%h expected %h", i, lu_if.loadout, e);
         end
      end
      rst_n = 1'b1;
      idle_bus();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      lu_if.instbus1 = 40'h0;
      lu_if.instbus2 = 40'h0;
      lu_if.data_in  = 32'h0;
      #2;
      test_reset();
      test_dual_held();
      test_single();
      test_filter();
      test_conflict();
      test_busy_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
